ide_disk: RTL and testbench
===========================

IDE_DISK -- requirements
Module: ide_disk

Interface
REQ-001 SHALL have parameter SECTORS, default 64: number of 512-byte sectors in the backing store.
REQ-002 SHALL have parameter BUSY_CYCLES, default 4: clk cycles that BSY is held per command or sector phase.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 ide_data_in  input  16  host write data, sampled on the diow assert edge.
REQ-007 ide_data_out  output  16  read data, registered on the dior assert edge and held until the next read.
REQ-008 ide_dior  input  1  active-low read strobe; the host drives the bus only while this is high.
REQ-009 ide_diow  input  1  active-low write strobe.
REQ-010 ide_cs  input  2  active-low chip selects; 2'b10 = command block, 2'b01 = control block.
REQ-011 ide_da  input  3  register address.

Function
REQ-012 SHALL synchronise dior/diow through 2 flops; an access = high-to-low transition of the synchronised strobe; both strobes asserting in the same cycle SHALL be ignored.
REQ-013 Command block map: da=0 data (16-bit), 1 error(R)/features(W), 2 sector count, 3/4/5 LBA[7:0]/[15:8]/[23:16], 6 device (LBA[27:24] in bits 3:0), 7 status(R)/command(W).
REQ-014 Control block: da=6 read = alternate status (no side effect); write = device control, bit2 SRST acts as soft reset per REQ-026.
REQ-015 8-bit register reads SHALL return the value in bits 7:0, zero in bits 15:8; unmapped reads SHALL return 16'h0000.
REQ-016 Status bits: BSY=0x80, DRDY=0x40, DSC=0x10, DRQ=0x08, ERR=0x01; idle status = 0x50.
REQ-017 State machine: IDLE, BUSY, DRQ_READ, DRQ_WRITE, WRITE_COMMIT.
REQ-018 Task-file writes while BSY=1 SHALL be ignored; command writes while BSY or DRQ is set SHALL be ignored.
REQ-019 Command 0x20 (READ SECTORS): IDLE->BUSY (status 0x90) for BUSY_CYCLES, then DRQ_READ (status 0x58) with word index 0.
REQ-020 DRQ_READ: each data read returns word[index] of the current sector, low byte = byte 2n, and increments index; after word 255, sector count decrements and LBA increments; if count reaches 0 -> IDLE (0x50), else BUSY then DRQ_READ for the next sector.
REQ-021 Command 0x30 (WRITE SECTORS): IDLE->DRQ_WRITE (0x58) immediately; each data write stores ide_data_in at word[index] and increments index; after word 255 -> WRITE_COMMIT (0x90) for BUSY_CYCLES, then next sector (DRQ_WRITE) or IDLE when count reaches 0.
REQ-022 Sector count 0 SHALL mean 256 sectors.
REQ-023 Data-register accesses outside the DRQ states SHALL read 16'h0000 and be ignored on write.
REQ-024 If a start LBA, or any LBA reached during a transfer, is >= SECTORS: abort, status 0x51, error 0x10 (IDNF), state IDLE.
REQ-025 Any other command code: status 0x51, error 0x04 (ABRT), IDLE; error register clears to 0x00 on the next accepted command.
REQ-026 SRST=1 SHALL return the state machine and registers to their reset values while preserving storage; SRST=0 releases it.

Reset
REQ-027 reset_n low: state IDLE, status 0x50, error 0x01 (diagnostic pass), sector count 0x01, LBA/device/features 0x00, word index 0, ide_data_out 16'h0000, synchroniser flops high.
REQ-028 Storage contents SHALL NOT be altered by reset; reset mid-transfer aborts with no partial commit beyond words already written.

Structure
REQ-029 Package ide_disk_pkg SHALL hold register addresses, status bit masks, command codes (0x20, 0x30), error codes (0x04, 0x10) and the state enum.
REQ-030 Storage SHALL be one sub-module ide_disk_store: a single-port SECTORS*256 x 16 synchronous RAM addressed by {LBA, index}.

Verification
REQ-031 Reset, then read cs=10 da=7 -> 0x0050; read da=1 -> 0x0001; read da=2 -> 0x0001.
REQ-032 Write count=1, LBA=5, cmd 0x30, then 256 words 16'hA500+i -> status returns 0x50 after BUSY_CYCLES; cmd 0x20 on LBA 5 -> reads return A500..A5FF in order, then status 0x50.
REQ-033 Count=2 from LBA 7: read 512 words -> BSY is seen between the sectors; final LBA low reads 0x09 and count reads 0x00.
REQ-034 LBA=SECTORS with cmd 0x20 -> status 0x51, error 0x10; then cmd 0xEC -> status 0x51, error 0x04.
REQ-035 Both strobes asserted together on da=7 with data 0x20 -> no command starts and status stays 0x50.
REQ-036 Assert reset_n low during DRQ_READ -> status 0x50; previously written sector data remains intact on re-read.

Source files
------------

// File: rtl/ide_disk_pkg.sv
// Shared definitions for the IDE disk model: task-file addresses, status/error
// encodings, command codes and the controller state enum.
package ide_disk_pkg;

    localparam logic [1:0] CS_CMD = 2'b10;
    localparam logic [1:0] CS_CTL = 2'b01;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_ERROR  = 3'd1;
    localparam logic [2:0] ADDR_COUNT  = 3'd2;
    localparam logic [2:0] ADDR_LBA0   = 3'd3;
    localparam logic [2:0] ADDR_LBA1   = 3'd4;
    localparam logic [2:0] ADDR_LBA2   = 3'd5;
    localparam logic [2:0] ADDR_DEVICE = 3'd6;
    localparam logic [2:0] ADDR_STATUS = 3'd7;
    localparam logic [2:0] ADDR_DEVCTL = 3'd6;

    localparam logic [7:0] ST_BSY  = 8'h80;
    localparam logic [7:0] ST_DRDY = 8'h40;
    localparam logic [7:0] ST_DSC  = 8'h10;
    localparam logic [7:0] ST_DRQ  = 8'h08;
    localparam logic [7:0] ST_ERR  = 8'h01;

    localparam logic [7:0] CMD_READ  = 8'h20;
    localparam logic [7:0] CMD_WRITE = 8'h30;

    localparam logic [7:0] ERR_DIAG = 8'h01;
    localparam logic [7:0] ERR_ABRT = 8'h04;
    localparam logic [7:0] ERR_IDNF = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_DRQ_READ,
        S_DRQ_WRITE,
        S_WRITE_COMMIT
    } ide_state_e;

    function automatic int lba_bits(input int sectors);
        return (sectors > 1) ? $clog2(sectors) : 1;
    endfunction

    function automatic logic [7:0] status_of(input ide_state_e st, input logic err);
        case (st)
            S_BUSY, S_WRITE_COMMIT:  return ST_BSY | ST_DSC;
            S_DRQ_READ, S_DRQ_WRITE: return ST_DRDY | ST_DSC | ST_DRQ;
            default:                 return ST_DRDY | ST_DSC | (err ? ST_ERR : 8'h00);
        endcase
    endfunction

endpackage

// File: rtl/ide_disk_if.sv
// IDE host bus: strobes, chip selects, register address and both data directions.
interface ide_disk_if;
    logic [15:0] ide_data_in;
    logic [15:0] ide_data_out;
    logic        ide_dior;
    logic        ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;

    modport master (
        output ide_data_in, ide_dior, ide_diow, ide_cs, ide_da,
        input  ide_data_out
    );

    modport slave (
        input  ide_data_in, ide_dior, ide_diow, ide_cs, ide_da,
        output ide_data_out
    );
endinterface

// File: rtl/ide_disk_store.sv
// Sector backing store: single-port synchronous RAM of 16-bit words, no reset so
// contents survive both hard and soft reset.
module ide_disk_store
    import ide_disk_pkg::*;
#(
    parameter int SECTORS = 64
) (
    input  logic                            clk,
    input  logic                            we_i,
    input  logic [lba_bits(SECTORS)+7:0]    addr_i,
    input  logic [15:0]                     wdata_i,
    output logic [15:0]                     rdata_o
);

    logic [15:0] mem_q [SECTORS*256];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/ide_disk.sv
// IDE disk device model: strobe synchroniser, task-file registers and the
// PIO read/write sector state machine in front of the sector store.
module ide_disk
    import ide_disk_pkg::*;
#(
    parameter int SECTORS     = 64,
    parameter int BUSY_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    ide_disk_if.slave  bus
);

    localparam int LBA_W = lba_bits(SECTORS);
    localparam int BC_W  = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [BC_W-1:0] BUSY_LOAD = BC_W'(BUSY_CYCLES - 1);

    logic dior_meta_q, dior_sync_q, dior_prev_q;
    logic diow_meta_q, diow_sync_q, diow_prev_q;

    ide_state_e      state_q, state_d;
    logic [BC_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      count_q, count_d;
    logic [7:0]      lba0_q, lba0_d, lba1_q, lba1_d, lba2_q, lba2_d;
    logic [7:0]      dev_q, dev_d;
    logic [7:0]      error_q, error_d;
    logic            err_flag_q, err_flag_d;
    logic [15:0]     data_out_q, data_out_d;
    logic            srst_q, srst_d;

    logic            acc_rd, acc_wr, bsy, adv_sector, ram_we;
    logic            lba_oob, inc_oob;
    logic [27:0]     lba_w, lba_inc;
    logic [7:0]      status;
    logic [15:0]     ram_rdata;

    // Simultaneous strobes are treated as bus noise and dropped.
    assign acc_rd = dior_prev_q & ~dior_sync_q & ~(diow_prev_q & ~diow_sync_q);
    assign acc_wr = diow_prev_q & ~diow_sync_q & ~(dior_prev_q & ~dior_sync_q);

    assign lba_w   = {dev_q[3:0], lba2_q, lba1_q, lba0_q};
    assign lba_inc = lba_w + 28'd1;
    assign lba_oob = ({4'h0, lba_w}   >= 32'(SECTORS));
    assign inc_oob = ({4'h0, lba_inc} >= 32'(SECTORS));
    assign bsy     = (state_q == S_BUSY) || (state_q == S_WRITE_COMMIT);
    assign status  = status_of(state_q, err_flag_q);

    assign bus.ide_data_out = data_out_q;

    ide_disk_store #(.SECTORS(SECTORS)) u_store (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  ({lba_w[LBA_W-1:0], idx_q}),
        .wdata_i (bus.ide_data_in),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        idx_d      = idx_q;
        count_d    = count_q;
        lba0_d     = lba0_q;
        lba1_d     = lba1_q;
        lba2_d     = lba2_q;
        dev_d      = dev_q;
        error_d    = error_q;
        err_flag_d = err_flag_q;
        data_out_d = data_out_q;
        srst_d     = srst_q;
        ram_we     = 1'b0;
        adv_sector = 1'b0;

        case (state_q)
            S_BUSY: begin
                if (busy_cnt_q == '0) state_d = S_DRQ_READ;
                else                  busy_cnt_d = busy_cnt_q - BC_W'(1);
            end
            S_WRITE_COMMIT: begin
                if (busy_cnt_q == '0) adv_sector = 1'b1;
                else                  busy_cnt_d = busy_cnt_q - BC_W'(1);
            end
            default: ;
        endcase

        if (acc_rd) begin
            data_out_d = 16'h0000;
            if (bus.ide_cs == CS_CMD) begin
                case (bus.ide_da)
                    ADDR_DATA: begin
                        // RAM output already holds word[idx] since idx settled earlier.
                        if (state_q == S_DRQ_READ) begin
                            data_out_d = ram_rdata;
                            idx_d      = idx_q + 8'd1;
                            adv_sector = (idx_q == 8'hFF);
                        end
                    end
                    ADDR_ERROR:  data_out_d = {8'h00, error_q};
                    ADDR_COUNT:  data_out_d = {8'h00, count_q};
                    ADDR_LBA0:   data_out_d = {8'h00, lba0_q};
                    ADDR_LBA1:   data_out_d = {8'h00, lba1_q};
                    ADDR_LBA2:   data_out_d = {8'h00, lba2_q};
                    ADDR_DEVICE: data_out_d = {8'h00, dev_q};
                    default:     data_out_d = {8'h00, status};
                endcase
            end else if (bus.ide_cs == CS_CTL && bus.ide_da == ADDR_DEVCTL) begin
                data_out_d = {8'h00, status};
            end
        end

        if (acc_wr && bus.ide_cs == CS_CMD) begin
            case (bus.ide_da)
                ADDR_DATA: begin
                    if (state_q == S_DRQ_WRITE) begin
                        ram_we = 1'b1;
                        idx_d  = idx_q + 8'd1;
                        if (idx_q == 8'hFF) begin
                            state_d    = S_WRITE_COMMIT;
                            busy_cnt_d = BUSY_LOAD;
                        end
                    end
                end
                ADDR_STATUS: begin
                    if (state_q == S_IDLE) begin
                        error_d    = 8'h00;
                        err_flag_d = 1'b0;
                        idx_d      = 8'h00;
                        case (bus.ide_data_in[7:0])
                            CMD_READ, CMD_WRITE: begin
                                if (lba_oob) begin
                                    error_d    = ERR_IDNF;
                                    err_flag_d = 1'b1;
                                end else if (bus.ide_data_in[7:0] == CMD_READ) begin
                                    state_d    = S_BUSY;
                                    busy_cnt_d = BUSY_LOAD;
                                end else begin
                                    state_d = S_DRQ_WRITE;
                                end
                            end
                            default: begin
                                error_d    = ERR_ABRT;
                                err_flag_d = 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    // Features (da=1) is accepted but unused: no command here takes it.
                    if (!bsy) begin
                        case (bus.ide_da)
                            ADDR_COUNT:  count_d = bus.ide_data_in[7:0];
                            ADDR_LBA0:   lba0_d  = bus.ide_data_in[7:0];
                            ADDR_LBA1:   lba1_d  = bus.ide_data_in[7:0];
                            ADDR_LBA2:   lba2_d  = bus.ide_data_in[7:0];
                            ADDR_DEVICE: dev_d   = bus.ide_data_in[7:0];
                            default: ;
                        endcase
                    end
                end
            endcase
        end

        if (adv_sector) begin
            count_d                         = count_q - 8'd1;
            {dev_d[3:0], lba2_d, lba1_d, lba0_d} = lba_inc;
            idx_d                           = 8'h00;
            if (count_q == 8'd1) begin
                state_d = S_IDLE;
            end else if (inc_oob) begin
                state_d    = S_IDLE;
                error_d    = ERR_IDNF;
                err_flag_d = 1'b1;
            end else if (state_q == S_DRQ_READ) begin
                state_d    = S_BUSY;
                busy_cnt_d = BUSY_LOAD;
            end else begin
                state_d = S_DRQ_WRITE;
            end
        end

        if (srst_q) begin
            state_d    = S_IDLE;
            busy_cnt_d = '0;
            idx_d      = 8'h00;
            count_d    = 8'h01;
            lba0_d     = 8'h00;
            lba1_d     = 8'h00;
            lba2_d     = 8'h00;
            dev_d      = 8'h00;
            error_d    = ERR_DIAG;
            err_flag_d = 1'b0;
            data_out_d = 16'h0000;
            ram_we     = 1'b0;
        end

        if (acc_wr && bus.ide_cs == CS_CTL && bus.ide_da == ADDR_DEVCTL) begin
            srst_d = bus.ide_data_in[2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dior_meta_q <= 1'b1;
            dior_sync_q <= 1'b1;
            dior_prev_q <= 1'b1;
            diow_meta_q <= 1'b1;
            diow_sync_q <= 1'b1;
            diow_prev_q <= 1'b1;
            state_q     <= S_IDLE;
            busy_cnt_q  <= '0;
            idx_q       <= 8'h00;
            count_q     <= 8'h01;
            lba0_q      <= 8'h00;
            lba1_q      <= 8'h00;
            lba2_q      <= 8'h00;
            dev_q       <= 8'h00;
            error_q     <= ERR_DIAG;
            err_flag_q  <= 1'b0;
            data_out_q  <= 16'h0000;
            srst_q      <= 1'b0;
        end else begin
            dior_meta_q <= bus.ide_dior;
            dior_sync_q <= dior_meta_q;
            dior_prev_q <= dior_sync_q;
            diow_meta_q <= bus.ide_diow;
            diow_sync_q <= diow_meta_q;
            diow_prev_q <= diow_sync_q;
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            lba0_q      <= lba0_d;
            lba1_q      <= lba1_d;
            lba2_q      <= lba2_d;
            dev_q       <= dev_d;
            error_q     <= error_d;
            err_flag_q  <= err_flag_d;
            data_out_q  <= data_out_d;
            srst_q      <= srst_d;
        end
    end

endmodule

// File: tb/tb_ide_disk.sv
// Self-checking bench for ide_disk: host PIO transfers against a bench-side
// sector model, with expected read values queued before each bus read.
module tb_ide_disk;
    import ide_disk_pkg::*;

    localparam int SECTORS = 64;
    localparam int BC      = 24;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ide_disk_if bus();

    ide_disk #(.SECTORS(SECTORS), .BUSY_CYCLES(BC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        sb_q[$];
    logic [15:0] model [SECTORS*256];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] d);
        bus.ide_cs = cs; bus.ide_da = da; bus.ide_data_in = d;
        @(negedge clk);
        bus.ide_diow = 1'b0;
        repeat (6) @(negedge clk);
        bus.ide_diow = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] cs, input logic [2:0] da, output logic [15:0] d);
        bus.ide_cs = cs; bus.ide_da = da;
        @(negedge clk);
        bus.ide_dior = 1'b0;
        repeat (6) @(negedge clk);
        d = bus.ide_data_out;
        bus.ide_dior = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_read(input string tag, input logic [1:0] cs, input logic [2:0] da,
                               input logic [15:0] exp);
        exp_t        e;
        logic [15:0] got;
        e.tag = tag; e.val = exp;
        sb_q.push_back(e);
        bus_read(cs, da, got);
        e = sb_q.pop_front();
        check(e.tag, got, e.val);
    endtask

    // Bounded status poll; the final observed value is what gets compared.
    task automatic poll_status(input string tag, input logic [15:0] exp, input int max_reads);
        exp_t        e;
        logic [15:0] s;
        int          n = 0;
        e.tag = tag; e.val = exp;
        sb_q.push_back(e);
        do begin
            bus_read(CS_CMD, ADDR_STATUS, s);
            n++;
        end while (s !== exp && n < max_reads);
        e = sb_q.pop_front();
        check(e.tag, s, e.val);
    endtask

    task automatic set_taskfile(input int count, input int lba);
        bus_write(CS_CMD, ADDR_COUNT,  16'(count & 255));
        bus_write(CS_CMD, ADDR_LBA0,   16'(lba & 255));
        bus_write(CS_CMD, ADDR_LBA1,   16'((lba >> 8) & 255));
        bus_write(CS_CMD, ADDR_LBA2,   16'((lba >> 16) & 255));
        bus_write(CS_CMD, ADDR_DEVICE, 16'(8'h40 | ((lba >> 24) & 15)));
    endtask

    task automatic write_words(input int lba, input int first, input int last);
        for (int i = first; i <= last; i++)
            bus_write(CS_CMD, ADDR_DATA, model[lba*256 + i]);
    endtask

    task automatic read_sector(input int lba, input int nwords, input string tag);
        for (int i = 0; i < nwords; i++)
            expect_read($sformatf("%s_w%0d", tag, i), CS_CMD, ADDR_DATA, model[lba*256 + i]);
    endtask

    task automatic skip_sector();
        logic [15:0] d;
        for (int i = 0; i < 256; i++) bus_read(CS_CMD, ADDR_DATA, d);
    endtask

    task automatic both_strobes(input logic [2:0] da, input logic [15:0] d);
        bus.ide_cs = CS_CMD; bus.ide_da = da; bus.ide_data_in = d;
        @(negedge clk);
        bus.ide_dior = 1'b0; bus.ide_diow = 1'b0;
        repeat (6) @(negedge clk);
        bus.ide_dior = 1'b1; bus.ide_diow = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            model[5*256 + i] = 16'(16'hA500 + i);
            model[7*256 + i] = 16'((7*256 + i) ^ 16'h3C3C);
            model[8*256 + i] = 16'((8*256 + i) ^ 16'h3C3C);
        end
        reset_n = 1'b0;
        bus.ide_dior = 1'b1; bus.ide_diow = 1'b1;
        bus.ide_cs = 2'b11; bus.ide_da = 3'd0; bus.ide_data_in = 16'h0000;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        expect_read("rst_status", CS_CMD, ADDR_STATUS, 16'h0050);
        expect_read("rst_error",  CS_CMD, ADDR_ERROR,  16'h0001);
        expect_read("rst_count",  CS_CMD, ADDR_COUNT,  16'h0001);
        expect_read("rst_lba0",   CS_CMD, ADDR_LBA0,   16'h0000);
        expect_read("alt_status", CS_CTL, ADDR_DEVCTL, 16'h0050);
        expect_read("unmapped",   2'b11,  ADDR_STATUS, 16'h0000);
        expect_read("data_idle",  CS_CMD, ADDR_DATA,   16'h0000);

        both_strobes(ADDR_STATUS, 16'h0020);
        expect_read("both_strb", CS_CMD, ADDR_STATUS, 16'h0050);

        // Single-sector write to LBA 5 with a stray command mid-transfer.
        set_taskfile(1, 5);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_WRITE));
        expect_read("wr_drq", CS_CMD, ADDR_STATUS, 16'h0058);
        write_words(5, 0, 99);
        bus_write(CS_CMD, ADDR_STATUS, 16'h00EC);
        expect_read("cmd_in_drq", CS_CMD, ADDR_STATUS, 16'h0058);
        write_words(5, 100, 255);
        expect_read("wr_commit", CS_CMD, ADDR_STATUS, 16'h0090);
        bus_write(CS_CMD, ADDR_LBA0, 16'h0033);
        poll_status("wr_done", 16'h0050, 20);
        expect_read("wr_lba_next", CS_CMD, ADDR_LBA0,  16'h0006);
        expect_read("wr_count0",   CS_CMD, ADDR_COUNT, 16'h0000);
        expect_read("wr_err_clr",  CS_CMD, ADDR_ERROR, 16'h0000);

        set_taskfile(1, 5);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_READ));
        poll_status("rd5_drq", 16'h0058, 20);
        read_sector(5, 256, "rd5");
        expect_read("rd5_done", CS_CMD, ADDR_STATUS, 16'h0050);

        // Two sectors from LBA 7: write then read back with BSY between sectors.
        set_taskfile(2, 7);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_WRITE));
        write_words(7, 0, 255);
        poll_status("wr78_next", 16'h0058, 20);
        write_words(8, 0, 255);
        poll_status("wr78_done", 16'h0050, 20);

        set_taskfile(2, 7);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_READ));
        poll_status("rd7_drq", 16'h0058, 20);
        read_sector(7, 256, "rd7");
        expect_read("rd78_bsy", CS_CMD, ADDR_STATUS, 16'h0090);
        poll_status("rd8_drq", 16'h0058, 20);
        read_sector(8, 256, "rd8");
        expect_read("rd78_done",  CS_CMD, ADDR_STATUS, 16'h0050);
        expect_read("rd78_lba0",  CS_CMD, ADDR_LBA0,   16'h0009);
        expect_read("rd78_count", CS_CMD, ADDR_COUNT,  16'h0000);

        set_taskfile(1, SECTORS);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_READ));
        expect_read("idnf_status", CS_CMD, ADDR_STATUS, 16'h0051);
        expect_read("idnf_error",  CS_CMD, ADDR_ERROR,  16'h0010);
        bus_write(CS_CMD, ADDR_STATUS, 16'h00EC);
        expect_read("abrt_status", CS_CMD, ADDR_STATUS, 16'h0051);
        expect_read("abrt_error",  CS_CMD, ADDR_ERROR,  16'h0004);

        // Count 0 means 256 sectors, so the run walks off the end at LBA 64.
        set_taskfile(0, SECTORS - 2);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_READ));
        poll_status("c0_drq1", 16'h0058, 20);
        skip_sector();
        poll_status("c0_drq2", 16'h0058, 20);
        skip_sector();
        expect_read("c0_status", CS_CMD, ADDR_STATUS, 16'h0051);
        expect_read("c0_error",  CS_CMD, ADDR_ERROR,  16'h0010);
        expect_read("c0_count",  CS_CMD, ADDR_COUNT,  16'h00FE);
        expect_read("c0_lba0",   CS_CMD, ADDR_LBA0,   16'(SECTORS));

        // Hard reset part-way through a read, then re-read the sector.
        set_taskfile(1, 5);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_READ));
        poll_status("rr_drq", 16'h0058, 20);
        expect_read("rr_err_clr", CS_CMD, ADDR_ERROR, 16'h0000);
        read_sector(5, 10, "rr_part");
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_read("rr_status", CS_CMD, ADDR_STATUS, 16'h0050);
        expect_read("rr_error",  CS_CMD, ADDR_ERROR,  16'h0001);
        expect_read("rr_data",   CS_CMD, ADDR_DATA,   16'h0000);
        set_taskfile(1, 5);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_READ));
        poll_status("rr_drq2", 16'h0058, 20);
        read_sector(5, 256, "rr_full");
        expect_read("rr_done", CS_CMD, ADDR_STATUS, 16'h0050);

        // Soft reset restores the task file without touching storage.
        set_taskfile(3, 18);
        bus_write(CS_CMD, ADDR_STATUS, 16'h00EC);
        bus_write(CS_CTL, ADDR_DEVCTL, 16'h0004);
        bus_write(CS_CMD, ADDR_LBA0, 16'h0077);
        bus_write(CS_CTL, ADDR_DEVCTL, 16'h0000);
        expect_read("srst_status", CS_CMD, ADDR_STATUS, 16'h0050);
        expect_read("srst_error",  CS_CMD, ADDR_ERROR,  16'h0001);
        expect_read("srst_count",  CS_CMD, ADDR_COUNT,  16'h0001);
        expect_read("srst_lba0",   CS_CMD, ADDR_LBA0,   16'h0000);
        set_taskfile(1, 7);
        bus_write(CS_CMD, ADDR_STATUS, 16'(CMD_READ));
        poll_status("srst_drq", 16'h0058, 20);
        read_sector(7, 16, "srst_rd7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
